jtframe_shram_arb: RTL and testbench

- Multi-port shared work RAM with built-in arbiter and per-port Z80-style wait generation.
- Generalises the two-CPU time-shared work RAM (main/sub drive flags) to NPORT requesters.
- Adds configurable width and depth, and round-robin fairness.
- Sits between CPU address decoders (cs, wr) and an inferred single-port RAM; wait_n outputs are ANDed with ROM wait gates in the parent.

---
 rtl/jtframe_shram_pkg.sv | 28 ++
 rtl/jtframe_shram_mem.sv | 24 ++
 rtl/jtframe_shram_arb.sv | 85 ++++++++
 tb/tb_jtframe_shram_arb.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_shram_pkg.sv
// jtframe_shram_pkg: shared types and the round-robin picker for the shared work RAM arbiter.
package jtframe_shram_pkg;

    localparam int MAXPORT = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

    // Scan req from ptr upward (mod nport); the first requester found wins.
    function automatic logic [MAXPORT-1:0] rr_pick(
        input logic [MAXPORT-1:0] req,
        input logic [1:0]         ptr,
        input int                 nport
    );
        logic [MAXPORT-1:0] g;
        int                 idx;
        g = '0;
        for (int k = MAXPORT-1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= nport) idx -= nport;
            if (k < nport && req[idx[1:0]]) begin
                g = '0;
                g[idx[1:0]] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/jtframe_shram_mem.sv
// jtframe_shram_mem: single-port RAM with a registered read-old output cleared by reset.
module jtframe_shram_mem #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk)
        if (we) mem[addr] <= din;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)  dout <= '0;
        else if (en) dout <= mem[addr];

endmodule

// File: rtl/jtframe_shram_arb.sv
// jtframe_shram_arb: NPORT-way arbitrated shared work RAM with per-port Z80-style wait_n.
// Define JTFRAME_SHRAM_FIXPRIO_EN for fixed lowest-index priority instead of round-robin.
module jtframe_shram_arb #(
    parameter int NPORT = 2,
    parameter int AW    = 13,
    parameter int DW    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NPORT-1:0]    cs,
    input  logic [NPORT-1:0]    we,
    input  logic [NPORT*AW-1:0] addr,
    input  logic [NPORT*DW-1:0] din,
    output logic [DW-1:0]       dout,
    output logic [NPORT-1:0]    wait_n,
    output logic [NPORT-1:0]    gnt
);
    import jtframe_shram_pkg::*;

    state_t             st;
    logic [1:0]         gi;
    logic [1:0]         nxt;
    logic [MAXPORT-1:0] cs_x;
    logic [MAXPORT-1:0] gnt_x;
    logic [MAXPORT-1:0] pick_idle;
    logic [MAXPORT-1:0] pick_hand;
    logic               rel;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_din;

    always_comb begin
        gi = '0;
        for (int i = 0; i < NPORT; i++)
            if (gnt[i]) gi = 2'(i);
    end

    assign nxt   = (int'(gi) == NPORT-1) ? 2'd0 : gi + 2'd1;
    assign cs_x  = MAXPORT'(cs);
    assign gnt_x = MAXPORT'(gnt);
    assign rel   = ~|(cs & gnt);

`ifdef JTFRAME_SHRAM_FIXPRIO_EN
    assign pick_idle = rr_pick(cs_x, 2'd0, NPORT);
    assign pick_hand = rr_pick(cs_x & ~gnt_x, 2'd0, NPORT);
`else
    logic [1:0] rr;
    assign pick_idle = rr_pick(cs_x, rr, NPORT);
    assign pick_hand = rr_pick(cs_x & ~gnt_x, nxt, NPORT);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                 rr <= '0;
        else if (st != IDLE && rel) rr <= nxt;
`endif

    // Releasing owner hands straight over to the next requester; pick_hand is 0 if none.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st  <= IDLE;
            gnt <= '0;
        end else if (st == IDLE) begin
            if (|cs) begin
                st  <= ACCESS;
                gnt <= NPORT'(pick_idle);
            end
        end else if (rel) begin
            st  <= |(cs & ~gnt) ? ACCESS : IDLE;
            gnt <= NPORT'(pick_hand);
        end else
            st <= HOLD;

    assign ram_addr = addr[int'(gi)*AW +: AW];
    assign ram_din  = din[int'(gi)*DW +: DW];
    assign wait_n   = ~cs | (gnt & {NPORT{st == HOLD}});

    jtframe_shram_mem #(.AW(AW), .DW(DW)) u_mem (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (|gnt),
        .we   (|(gnt & we & cs)),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (dout)
    );

endmodule

// File: tb/tb_jtframe_shram_arb.sv
// tb_jtframe_shram_arb: self-checking bench for the 4-port shared RAM arbiter.
module tb_jtframe_shram_arb;

    localparam int NP = 4;
    localparam int AW = 13;
    localparam int DW = 8;

    typedef struct {
        int          p;
        bit          w;
        logic [12:0] a;
        logic [7:0]  d;
        logic [7:0]  rd;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NP-1:0]    cs;
    logic [NP-1:0]    we;
    logic [NP*AW-1:0] addr;
    logic [NP*DW-1:0] din;
    logic [DW-1:0]    dout;
    logic [NP-1:0]    wait_n;
    logic [NP-1:0]    gnt;

    int          n_chk = 0;
    int          n_fail = 0;
    vec_t        tv[9];
    logic [7:0]  sb[$];
    logic [7:0]  e;
    logic [3:0]  prev;
    int          lat;
    int          ng;
    int          rel[4];
    int          ord[5];
    int          gcyc[5];
    int          expo[5];

    always #5 clk = ~clk;

    jtframe_shram_arb #(.NPORT(NP), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cs    (cs),
        .we    (we),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .wait_n(wait_n),
        .gnt   (gnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setp(input int p, input bit c, input bit w, input logic [12:0] a, input logic [7:0] d);
        cs[p] = c;
        we[p] = w;
        addr[p*AW +: AW] = a;
        din[p*DW +: DW] = d;
    endtask

    task automatic do_reset();
        cs = '0;
        we = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tv = '{'{0, 1'b1, 13'h0123, 8'h5A, 8'h00},
               '{0, 1'b0, 13'h0123, 8'h00, 8'h5A},
               '{2, 1'b1, 13'h1FFE, 8'h11, 8'h00},
               '{1, 1'b1, 13'h1FFF, 8'hC3, 8'h00},
               '{1, 1'b0, 13'h1FFF, 8'h00, 8'hC3},
               '{3, 1'b0, 13'h1FFE, 8'h00, 8'h11},
               '{3, 1'b1, 13'h0000, 8'hA5, 8'h00},
               '{2, 1'b0, 13'h0000, 8'h00, 8'hA5},
               '{1, 1'b0, 13'h0123, 8'h00, 8'h5A}};
        expo = '{0, 1, 2, 3, 0};

        cs = 4'b0101; we = '0; addr = '0; din = '0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_dout", dout, 0);
        chk("rst_wait", wait_n, 4'b1010);
        do_reset();

        // single-port transactions, read expectations through the scoreboard
        foreach (tv[k]) begin
            setp(tv[k].p, 1'b1, tv[k].w, tv[k].a, tv[k].d);
            if (!tv[k].w) sb.push_back(tv[k].rd);
            lat = 0;
            #1;
            while (!wait_n[tv[k].p] && lat < 10) begin
                cyc();
                #1;
                lat++;
            end
            chk("tbl_latency", lat, 2);
            if (!tv[k].w) begin
                e = sb.pop_front();
                chk("tbl_read", dout, e);
            end
            cs[tv[k].p] = 1'b0;
            we[tv[k].p] = 1'b0;
            cyc();
        end

        // exact cycle timing of an uncontested read
        do_reset();
        setp(0, 1'b1, 1'b0, 13'h0123, 8'h00);
        #1;
        chk("single_wait_c0", wait_n[0], 0);
        chk("single_gnt_c0", gnt, 0);
        cyc(); #1;
        chk("single_wait_c1", wait_n[0], 0);
        chk("single_gnt_c1", gnt, 4'b0001);
        cyc(); #1;
        chk("single_wait_c2", wait_n[0], 1);
        chk("single_gnt_c2", gnt, 4'b0001);
        chk("single_dout", dout, 8'h5A);
        cs[0] = 1'b0;
        cyc(); #1;
        chk("single_idle", gnt, 0);

        // contention and back-to-back handover
        do_reset();
        setp(0, 1'b1, 1'b0, 13'h0123, 8'h00);
        setp(1, 1'b1, 1'b0, 13'h1FFF, 8'h00);
        cyc(); #1;
        chk("cont_gnt_c1", gnt, 4'b0001);
        chk("cont_wait_c1", wait_n, 4'b1100);
        cyc(); #1;
        chk("cont_wait_c2", wait_n, 4'b1101);
        chk("cont_dout0", dout, 8'h5A);
        cs[0] = 1'b0;
        cyc(); #1;
        chk("cont_handover", gnt, 4'b0010);
        chk("cont_wait_c3", wait_n, 4'b1101);
        cyc(); #1;
        chk("cont_wait_c4", wait_n, 4'b1111);
        chk("cont_dout1", dout, 8'hC3);
        cs[1] = 1'b0;
        cyc();

        // abort right after ACCESS: one write only, rr moves to port 1
        do_reset();
        setp(0, 1'b1, 1'b1, 13'h0040, 8'h77);
        cyc(); #1;
        chk("abort_gnt_access", gnt, 4'b0001);
        cyc();
        cs[0] = 1'b0;
        din[7:0] = 8'h88;
        #1;
        chk("abort_gnt_rel", gnt, 4'b0001);
        chk("abort_wait", wait_n, 4'b1111);
        cyc(); #1;
        chk("abort_gnt_clear", gnt, 0);
        setp(0, 1'b1, 1'b0, 13'h0040, 8'h00);
        setp(1, 1'b1, 1'b0, 13'h0123, 8'h00);
        cyc(); #1;
        chk("abort_rr_next", gnt, 4'b0010);
        cyc(); #1;
        chk("abort_dout1", dout, 8'h5A);
        cs[1] = 1'b0;
        cyc(); #1;
        chk("abort_handover", gnt, 4'b0001);
        cyc(); #1;
        chk("abort_single_write", dout, 8'h77);
        cs[0] = 1'b0;
        cyc();

        // round-robin fairness with all four ports re-requesting
        do_reset();
        for (int i = 0; i < 4; i++) setp(i, 1'b1, 1'b0, 13'(i), 8'h00);
        prev = '0;
        ng = 0;
        rel = '{-1, -1, -1, -1};
        for (int c = 1; c < 60 && ng < 5; c++) begin
            cyc(); #1;
            if (gnt != 4'b0000 && gnt != prev) begin
                ord[ng] = $clog2(gnt);
                gcyc[ng] = c;
                rel[$clog2(gnt)] = c + 3;
                ng++;
            end
            prev = gnt;
            for (int i = 0; i < 4; i++) cs[i] = (rel[i] != c);
        end
        chk("fair_grant_count", ng, 5);
        for (int k = 0; k < ng; k++) begin
            chk("fair_order", ord[k], expo[k]);
            if (k > 0) chk("fair_gap", gcyc[k] - gcyc[k-1], 4);
        end
        cs = '0;
        repeat (3) cyc();

        // reset in the middle of HOLD, with rr left pointing at port 2
        do_reset();
        setp(1, 1'b1, 1'b0, 13'h1FFF, 8'h00);
        repeat (2) cyc();
        cs[1] = 1'b0;
        cyc();
        setp(0, 1'b1, 1'b0, 13'h0123, 8'h00);
        cyc(); cyc(); #1;
        chk("rhold_gnt", gnt, 4'b0001);
        chk("rhold_dout", dout, 8'h5A);
        cs = 4'b0110;
        rst_n = 1'b0;
        #1;
        chk("rhold_gnt_rst", gnt, 0);
        chk("rhold_dout_rst", dout, 0);
        chk("rhold_wait_rst", wait_n, 4'b1001);
        cyc();
        rst_n = 1'b1;
        cyc(); #1;
        chk("rhold_restart", gnt, 4'b0010);
        cs = '0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
